pwm_array: RTL



---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_compare_cell.sv | 53 +++++
 rtl/pwm_array.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the double-buffered PWM array.
package pwm_pkg;

    localparam int PWM_WIDTH = 13;
    localparam int PWM_DEPTH = 249;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    typedef logic [PWM_WIDTH-1:0] edge_t;

endpackage

// File: rtl/pwm_compare_cell.sv
// One PWM channel: active rise/fall edges, window compare against the shared
// time counter, and the registered output bit.
module pwm_compare_cell
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] time_cnt_i,
    input  logic [WIDTH-1:0] shadow_rise_i,
    input  logic [WIDTH-1:0] shadow_fall_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             pwm_q;
    logic             level_s;

    // Window test; fall < rise means the high phase wraps across the period end.
    always_comb begin
        level_s = 1'b0;
        if (rise_q <= fall_q) begin
            level_s = (rise_q <= time_cnt_i) && (time_cnt_i < fall_q);
        end else begin
            level_s = (rise_q <= time_cnt_i) || (time_cnt_i < fall_q);
        end
    end

    // Output register uses the pre-load edges, so the commit edge still emits old values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= '0;
            fall_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            pwm_q <= level_s & en_i;
            if (load_i) begin
                rise_q <= shadow_rise_i;
                fall_q <= shadow_fall_i;
            end else begin
                rise_q <= rise_q;
                fall_q <= fall_q;
            end
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_array.sv
// Multi-channel PWM with a shadow edge bank committed atomically at the period boundary.
// Optional per-channel output mask when PWM_ARRAY_MASK_EN is defined.
module pwm_array
    import pwm_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH,
    parameter int DEPTH  = PWM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WIDTH-1:0]  time_cnt_i,
    input  logic [WIDTH-1:0]  cycle_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  rise_i,
    input  logic [WIDTH-1:0]  fall_i,
    input  logic              commit_i,
`ifdef PWM_ARRAY_MASK_EN
    input  logic              mask_we_i,
    input  logic [DEPTH-1:0]  mask_i,
`endif
    output logic              busy_o,
    output logic              wr_err_o,
    output logic [DEPTH-1:0]  pwm_out_o
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shadow_rise_q [DEPTH];
    logic [WIDTH-1:0] shadow_fall_q [DEPTH];
    logic             wr_err_q;
    logic             wr_err_d;
    logic             load_s;
    logic             boundary_s;
    logic             idle_s;
    logic             addr_ok_s;
    logic [DEPTH-1:0] en_s;

    assign boundary_s = (time_cnt_i == (cycle_i - {{(WIDTH-1){1'b0}}, 1'b1}));
    assign idle_s     = (state_q == IDLE);
    assign addr_ok_s  = ({1'b0, addr_i} < DEPTH_L);

    // Commit FSM: a request accepted in IDLE always waits for a later boundary.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_i) begin
                    state_d = PENDING;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                if (boundary_s) begin
                    state_d = IDLE;
                    load_s  = 1'b1;
                end else begin
                    state_d = PENDING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropped-write detection.
    always_comb begin
        wr_err_d = we_i && (!idle_s || !addr_ok_s);
`ifdef PWM_ARRAY_MASK_EN
        wr_err_d = wr_err_d || (mask_we_i && !idle_s);
`endif
    end

    // Error pulse register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    // Shadow edge bank, writable only while no commit is outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_rise_q[i] <= '0;
                shadow_fall_q[i] <= '0;
            end
        end else if (we_i && idle_s && addr_ok_s) begin
            shadow_rise_q[addr_i] <= rise_i;
            shadow_fall_q[addr_i] <= fall_i;
        end else begin
            shadow_rise_q <= shadow_rise_q;
            shadow_fall_q <= shadow_fall_q;
        end
    end

`ifdef PWM_ARRAY_MASK_EN
    logic [DEPTH-1:0] shadow_mask_q;
    logic [DEPTH-1:0] active_mask_q;

    // Mask is double-buffered alongside the edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_mask_q <= '1;
            active_mask_q <= '1;
        end else begin
            if (mask_we_i && idle_s) begin
                shadow_mask_q <= mask_i;
            end else begin
                shadow_mask_q <= shadow_mask_q;
            end
            if (load_s) begin
                active_mask_q <= shadow_mask_q;
            end else begin
                active_mask_q <= active_mask_q;
            end
        end
    end

    assign en_s = active_mask_q;
`else
    assign en_s = '1;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        pwm_compare_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .load_i        (load_s),
            .en_i          (en_s[g]),
            .time_cnt_i    (time_cnt_i),
            .shadow_rise_i (shadow_rise_q[g]),
            .shadow_fall_i (shadow_fall_q[g]),
            .pwm_o         (pwm_out_o[g])
        );
    end

    assign busy_o   = (state_q == PENDING);
    assign wr_err_o = wr_err_q;

endmodule
